// File: rtl/frame_ptr_ctrl_if.sv
// Request handshake and register-file control bundle for the frame-pointer controller.
interface frame_ptr_ctrl_if;
  logic       Op_Valid;
  logic       Op_Call;
  logic [2:0] Op_Shift;
  logic       Op_Ready;
  logic [2:0] Actual_Rd;
  logic [2:0] Actual_Rs;
  logic [2:0] Actual_Rm;
  logic [3:0] Rd_Addr;
  logic [3:0] Rs_Addr;
  logic [3:0] Rm_Addr;
  logic [3:0] New_FP;
  logic       FP_move;
  logic       FP_push_up;
  logic [3:0] Cur_FP;
  logic [3:0] Depth;
  logic       Fault;
  logic [1:0] Fault_Code;
  logic       Fault_Clr;

  modport slave (
    input  Op_Valid, Op_Call, Op_Shift, Actual_Rd, Actual_Rs, Actual_Rm, Fault_Clr,
    output Op_Ready, Rd_Addr, Rs_Addr, Rm_Addr, New_FP, FP_move, FP_push_up,
           Cur_FP, Depth, Fault, Fault_Code
  );

  modport master (
    output Op_Valid, Op_Call, Op_Shift, Actual_Rd, Actual_Rs, Actual_Rm, Fault_Clr,
    input  Op_Ready, Rd_Addr, Rs_Addr, Rm_Addr, New_FP, FP_move, FP_push_up,
           Cur_FP, Depth, Fault, Fault_Code
  );
endinterface

// File: rtl/frame_ptr_ctrl.sv
// Frame-pointer controller: window-relative operand translation plus CALL/RTN
// window moves with a saved-FP stack and sticky fault reporting.
module frame_ptr_ctrl #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned FP_MAX      = 8
) (
  input logic              Clock,
  input logic              Reset_n,
  frame_ptr_ctrl_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MOVE = 1'b1;

  localparam logic [1:0] FC_OVERFLOW  = 2'd1;
  localparam logic [1:0] FC_UNDERFLOW = 2'd2;
  localparam logic [1:0] FC_RANGE     = 2'd3;

  logic [0:0] state_q, state_d;
  logic [3:0] cur_fp_q, cur_fp_d;
  logic [3:0] new_fp_q, new_fp_d;
  logic       push_up_q, push_up_d;
  logic [3:0] depth_q, depth_d;
  logic       fault_q, fault_d;
  logic [1:0] code_q, code_d;

  logic [3:0] stack_q [16];
  logic       push_en;
  logic       accept;
  logic       fault_new;
  logic [1:0] code_new;
  logic [4:0] call_target;

  assign accept      = bus.Op_Valid && (state_q == ST_IDLE);
  assign call_target = {1'b0, cur_fp_q} + {2'b00, bus.Op_Shift};

  always_comb begin
    state_d   = state_q;
    cur_fp_d  = cur_fp_q;
    new_fp_d  = new_fp_q;
    push_up_d = push_up_q;
    depth_d   = depth_q;
    fault_d   = fault_q;
    code_d    = code_q;
    push_en   = 1'b0;
    fault_new = 1'b0;
    code_new  = '0;

    if (state_q == ST_MOVE) begin
      cur_fp_d = new_fp_q;
      state_d  = ST_IDLE;
    end else if (accept) begin
      if (bus.Op_Call) begin
        if (depth_q == STACK_DEPTH[3:0]) begin
          fault_new = 1'b1;
          code_new  = FC_OVERFLOW;
        end else if (bus.Op_Shift == 3'd0 || call_target > FP_MAX[4:0]) begin
          fault_new = 1'b1;
          code_new  = FC_RANGE;
        end else begin
          push_en   = 1'b1;
          depth_d   = depth_q + 4'd1;
          new_fp_d  = call_target[3:0];
          push_up_d = 1'b0;
          state_d   = ST_MOVE;
        end
      end else begin
        if (depth_q == 4'd0) begin
          fault_new = 1'b1;
          code_new  = FC_UNDERFLOW;
        end else begin
          depth_d   = depth_q - 4'd1;
          new_fp_d  = stack_q[depth_q - 4'd1];
          push_up_d = 1'b1;
          state_d   = ST_MOVE;
        end
      end
    end

    // A fault raised in the same cycle as Fault_Clr takes priority over the clear.
    if (fault_new) begin
      fault_d = 1'b1;
      code_d  = code_new;
    end else if (bus.Fault_Clr) begin
      fault_d = 1'b0;
      code_d  = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      cur_fp_q  <= '0;
      new_fp_q  <= '0;
      push_up_q <= 1'b0;
      depth_q   <= '0;
      fault_q   <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_fp_q  <= cur_fp_d;
      new_fp_q  <= new_fp_d;
      push_up_q <= push_up_d;
      depth_q   <= depth_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge Clock) begin
    if (push_en) stack_q[depth_q] <= cur_fp_q;
  end

  assign bus.Op_Ready   = (state_q == ST_IDLE);
  assign bus.FP_move    = (state_q == ST_MOVE);
  assign bus.FP_push_up = push_up_q;
  assign bus.New_FP     = new_fp_q;
  assign bus.Cur_FP     = cur_fp_q;
  assign bus.Depth      = depth_q;
  assign bus.Fault      = fault_q;
  assign bus.Fault_Code = code_q;
  assign bus.Rd_Addr    = cur_fp_q + {1'b0, bus.Actual_Rd};
  assign bus.Rs_Addr    = cur_fp_q + {1'b0, bus.Actual_Rs};
  assign bus.Rm_Addr    = cur_fp_q + {1'b0, bus.Actual_Rm};

endmodule

// File: tb/tb_frame_ptr_ctrl.sv
// Directed and randomized checks of frame_ptr_ctrl against a queue-based model.
module tb_frame_ptr_ctrl;

  localparam int SD   = 4;
  localparam int FPMX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_fp;
  int m_stk[$];
  int m_fault;
  int m_code;

  frame_ptr_ctrl_if bus();

  frame_ptr_ctrl #(.STACK_DEPTH(SD), .FP_MAX(FPMX)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".cur_fp"}, 32'(bus.Cur_FP), 32'(m_fp));
    check({tag, ".depth"},  32'(bus.Depth),  32'(m_stk.size()));
    check({tag, ".fault"},  32'(bus.Fault),  32'(m_fault));
    check({tag, ".code"},   32'(bus.Fault_Code), 32'(m_code));
    check({tag, ".ready"},  32'(bus.Op_Ready), 32'd1);
    check({tag, ".move"},   32'(bus.FP_move), 32'd0);
  endtask

  task automatic check_addr(input string tag);
    int a, b, c;
    a = $urandom_range(0, 7);
    b = $urandom_range(0, 7);
    c = $urandom_range(0, 7);
    bus.Actual_Rd = 3'(a);
    bus.Actual_Rs = 3'(b);
    bus.Actual_Rm = 3'(c);
    #1;
    check({tag, ".rd"}, 32'(bus.Rd_Addr), 32'((m_fp + a) % 16));
    check({tag, ".rs"}, 32'(bus.Rs_Addr), 32'((m_fp + b) % 16));
    check({tag, ".rm"}, 32'(bus.Rm_Addr), 32'((m_fp + c) % 16));
  endtask

  // Issue one request starting #1 after a rising edge with the controller idle.
  task automatic req(input string tag, input bit call, input int shift, input bit clr);
    int f;
    int tgt;
    int old_fp;
    int rd;
    f = 0;
    tgt = 0;
    old_fp = m_fp;
    if (call) begin
      if (m_stk.size() == SD) f = 1;
      else if (shift == 0 || m_fp + shift > FPMX) f = 3;
      else begin
        tgt = m_fp + shift;
        m_stk.push_back(m_fp);
      end
    end else begin
      if (m_stk.size() == 0) f = 2;
      else tgt = m_stk.pop_back();
    end
    if (f != 0) begin
      m_fault = 1;
      m_code  = f;
    end else if (clr) begin
      m_fault = 0;
      m_code  = 0;
    end

    bus.Op_Valid  = 1'b1;
    bus.Op_Call   = call;
    bus.Op_Shift  = 3'(shift);
    bus.Fault_Clr = clr;
    @(posedge clk);
    #1;
    bus.Op_Valid  = 1'b0;
    bus.Op_Shift  = 3'($urandom_range(0, 7));
    bus.Op_Call   = 1'($urandom_range(0, 1));
    bus.Fault_Clr = 1'b0;

    if (f != 0) begin
      check_state({tag, ".flt"});
    end else begin
      check({tag, ".mv"},     32'(bus.FP_move),    32'd1);
      check({tag, ".newfp"},  32'(bus.New_FP),     32'(tgt));
      check({tag, ".dir"},    32'(bus.FP_push_up), call ? 32'd0 : 32'd1);
      check({tag, ".busy"},   32'(bus.Op_Ready),   32'd0);
      check({tag, ".oldfp"},  32'(bus.Cur_FP),     32'(old_fp));
      check({tag, ".depth"},  32'(bus.Depth),      32'(m_stk.size()));
      rd = $urandom_range(0, 7);
      bus.Actual_Rd = 3'(rd);
      #1;
      check({tag, ".rdmove"}, 32'(bus.Rd_Addr),    32'((old_fp + rd) % 16));
      @(posedge clk);
      #1;
      m_fp = tgt;
      check_state({tag, ".done"});
      check({tag, ".hold"},   32'(bus.New_FP),     32'(tgt));
    end
  endtask

  task automatic clr_only(input string tag);
    bus.Fault_Clr = 1'b1;
    @(posedge clk);
    #1;
    bus.Fault_Clr = 1'b0;
    m_fault = 0;
    m_code  = 0;
    check_state(tag);
  endtask

  initial begin
    bus.Op_Valid  = 1'b0;
    bus.Op_Call   = 1'b0;
    bus.Op_Shift  = '0;
    bus.Fault_Clr = 1'b0;
    bus.Actual_Rd = '0;
    bus.Actual_Rs = '0;
    bus.Actual_Rm = '0;
    m_fp = 0;
    m_fault = 0;
    m_code = 0;
    m_stk.delete();

    repeat (3) @(posedge clk);
    #1;
    check_state("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("rst_rel");

    bus.Actual_Rd = 3'd5;
    #1;
    check("xlat0", 32'(bus.Rd_Addr), 32'd5);

    req("call3", 1'b1, 3, 1'b0);
    bus.Actual_Rd = 3'd5;
    #1;
    check("xlat3", 32'(bus.Rd_Addr), 32'd8);

    req("call5", 1'b1, 5, 1'b0);
    check("nest_fp", 32'(bus.Cur_FP), 32'd8);
    req("rtn1", 1'b0, 0, 1'b0);
    req("rtn2", 1'b0, 0, 1'b0);
    check("nest_fp0", 32'(bus.Cur_FP), 32'd0);

    req("call3b", 1'b1, 3, 1'b0);
    req("range6", 1'b1, 6, 1'b0);
    check("range_code", 32'(bus.Fault_Code), 32'd3);
    req("shift0", 1'b1, 0, 1'b0);
    req("rtn3", 1'b0, 0, 1'b0);
    req("undfl", 1'b0, 0, 1'b0);
    check("undfl_code", 32'(bus.Fault_Code), 32'd2);

    clr_only("clr1");
    for (int unsigned i = 0; i < SD; i++) req("fill", 1'b1, 1, 1'b0);
    req("ovfl", 1'b1, 1, 1'b0);
    check("ovfl_code", 32'(bus.Fault_Code), 32'd1);
    check("ovfl_fp", 32'(bus.Cur_FP), 32'(SD));
    for (int unsigned i = 0; i < SD; i++) req("drain", 1'b0, 0, 1'b0);

    req("clr_vs_flt", 1'b0, 0, 1'b1);
    check("cvf_code", 32'(bus.Fault_Code), 32'd2);
    clr_only("clr2");

    req("call7", 1'b1, 7, 1'b0);
    req("edge8", 1'b1, 1, 1'b0);
    check("edge8_fp", 32'(bus.Cur_FP), 32'(FPMX));
    req("over8", 1'b1, 1, 1'b0);
    req("rtn_e1", 1'b0, 0, 1'b1);
    req("rtn_e2", 1'b0, 0, 1'b0);

    // Reset asserted while the move strobe is high
    bus.Op_Valid = 1'b1;
    bus.Op_Call  = 1'b1;
    bus.Op_Shift = 3'd2;
    @(posedge clk);
    #1;
    bus.Op_Valid = 1'b0;
    check("mid_mv", 32'(bus.FP_move), 32'd1);
    rst_n = 1'b0;
    #1;
    m_fp = 0;
    m_stk.delete();
    m_fault = 0;
    m_code = 0;
    check_state("mid_rst");
    check("mid_newfp", 32'(bus.New_FP), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req("post_rst_rtn", 1'b0, 0, 1'b0);
    check("post_rst_code", 32'(bus.Fault_Code), 32'd2);

    for (int unsigned i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5)      req("rnd_call", 1'b1, $urandom_range(0, 7), ($urandom_range(0, 7) == 0));
      else if (kind < 9) req("rnd_rtn", 1'b0, 0, ($urandom_range(0, 7) == 0));
      else begin
        @(posedge clk);
        #1;
        check_addr("rnd_addr");
      end
    end
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/frame_ptr_ctrl.md
# frame_ptr_ctrl

Frame-pointer controller that sits directly upstream of the 16-entry windowed register file. It translates 3-bit window-relative operand indices into 4-bit absolute register addresses and executes CALL/RTN window moves. For each move it drives the file's FP_move / FP_push_up / New_FP controls for exactly one cycle, and keeps a stack of saved frame pointers for nested calls.

## Interface
- STACK_DEPTH, 8, number of saved-FP entries (1..15)
- FP_MAX, 8, largest legal FP (16 registers minus 8-entry window)

- Clock  in  1  single clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Op_Valid  in  1  move request present
- Op_Call  in  1  1 = CALL, 0 = RTN; sampled with Op_Valid
- Op_Shift  in  3  CALL window advance I (1..7); ignored for RTN
- Op_Ready  out  1  controller can accept a request
- Actual_Rd, Actual_Rs, Actual_Rm  in  3 each  window-relative operand indices
- Rd_Addr, Rs_Addr, Rm_Addr  out  4 each  absolute addresses = FP + Actual_x
- New_FP  out  4  target FP presented to the register file
- FP_move  out  1  one-cycle window-move strobe
- FP_push_up  out  1  direction during FP_move: 0 = CALL (FP up), 1 = RTN (FP down)
- Cur_FP  out  4  current committed FP
- Depth  out  4  number of occupied stack entries
- Fault  out  1  sticky error flag
- Fault_Code  out  2  0 none, 1 stack overflow, 2 stack underflow, 3 window range
- Fault_Clr  in  1  clears Fault and Fault_Code

## Operation
- **States:** IDLE and MOVE. Op_Ready = (state == IDLE).
- **Accept:** a request is accepted when Op_Valid && Op_Ready on a rising edge.
- **Accepted CALL:**
  - If Depth == STACK_DEPTH: fault code 1. No move, state stays IDLE.
  - Else if Op_Shift == 0 or FP + Op_Shift > FP_MAX: fault code 3. No move.
  - Otherwise: push the current FP, register New_FP = FP + Op_Shift and FP_push_up = 0, go to MOVE.
- **Accepted RTN:**
  - If Depth == 0: fault code 2. No move.
  - Otherwise: pop the top entry, register New_FP = popped value and FP_push_up = 1, go to MOVE.
- **MOVE (one cycle):** FP_move = 1. On the exiting edge, Cur_FP <= New_FP, FP_move <= 0, state <= IDLE.
- **Address translation:** Rd/Rs/Rm_Addr are combinational from Cur_FP + Actual_x, 4-bit. They cannot overflow because FP ≤ 8 and Actual ≤ 7. During MOVE they still use the old FP, so a CALL write-back lands in the caller's frame.
- **Stack:** LIFO addressed by Depth.
  - Push writes entry[Depth] and increments Depth.
  - Pop reads entry[Depth-1] and decrements Depth.
  - A push and a pop never occur in the same cycle.
- **Faults:**
  - A faulting request is still consumed (handshake completes) and causes no change to FP or stack.
  - Fault sets and Fault_Code latches the new code.
  - Fault_Clr clears both. A new fault in the same cycle as Fault_Clr wins.
  - A later fault overwrites Fault_Code.
- **Reset (Reset_n low, any state including MOVE):** immediately forces IDLE, Cur_FP = 0, New_FP = 0, Depth = 0, FP_move = 0, FP_push_up = 0, Fault = 0, Fault_Code = 0. Stack contents are don't-care. Op_Ready = 1 after reset.

## Timing
- Accept edge N → FP_move high during cycle N+1 with New_FP and FP_push_up valid → Cur_FP updated at edge N+2.
- Op_Ready is low for exactly one cycle per successful move. Maximum throughput is one move every 2 cycles.
- A faulting request takes one cycle. Op_Ready stays high, and Fault is visible after edge N.
- New_FP and FP_push_up hold their last value outside MOVE.
- Depth updates at the accept edge N. Cur_FP lags Depth by one cycle.
- Op_Call and Op_Shift are don't-care when Op_Valid = 0.

## Test plan
- **Reset and translation:** reset, Actual_Rd = 5 → Rd_Addr = 5. CALL shift 3 → FP_move pulse for one cycle with New_FP = 3, FP_push_up = 0; afterwards Cur_FP = 3, Actual_Rd = 5 → Rd_Addr = 8, Depth = 1.
- **Nested calls and returns:** CALL 3 then CALL 5 → Cur_FP = 8, Depth = 2. RTN → New_FP = 3, FP_push_up = 1, Cur_FP = 3. RTN → Cur_FP = 0, Depth = 0.
- **Range and underflow faults:**
  - From Cur_FP = 3, CALL 6 → Fault = 1, Code = 3, no FP_move pulse, Cur_FP = 3.
  - CALL 0 → Code = 3.
  - RTN at Depth = 0 → Code = 2, Cur_FP unchanged.
- **Stack overflow:** STACK_DEPTH = 2. CALL 1, CALL 1, CALL 1 → third request gives Code = 1, Depth stays 2, Cur_FP = 2.
- **Clear vs. new fault:** Fault_Clr in the same cycle as a new underflow → Fault = 1, Code = 2. Fault_Clr alone → Fault = 0, Code = 0.
- **Reset mid-operation:** assert Reset_n low during the MOVE cycle → FP_move drops immediately, Cur_FP = 0, Depth = 0. After release, a RTN faults with Code = 2.
